rx_huge_page_sched: RTL and testbench

Schedules the host's 2 MB receive huge pages for the RX DMA path. It holds two host-supplied page base addresses in a ping-pong pair and generates the host destination address for every TLP the RX trigger logic issues. It answers the trigger's page-change request by retiring the current page, switching to the other slot and posting a page-closed notification to the interrupt/status logic.

---
 rtl/rx_huge_page_sched_pkg.sv | 17 +
 rtl/rx_hp_slot_regs.sv | 51 +++++
 rtl/rx_huge_page_sched.sv | 123 ++++++++++++
 tb/tb_rx_huge_page_sched.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/rx_huge_page_sched_pkg.sv
// rx_huge_page_sched_pkg: constants and FSM encodings shared by the RX huge-page scheduler and RX trigger.
package rx_huge_page_sched_pkg;

    localparam int HP_HDR_QWORDS   = 16;
    localparam int HP_PAGE_QW_LOG2 = 18;
    localparam int HP_HOST_AW      = 64;
    localparam logic [HP_HOST_AW-1:0] HP_ALIGN_MASK = ~64'h1F_FFFF;

    typedef enum logic [4:0] {
        S_IDLE   = 5'b00001,
        S_ACTIVE = 5'b00010,
        S_WAIT   = 5'b00100,
        S_SWITCH = 5'b01000,
        S_NOTIFY = 5'b10000
    } hp_state_e;

endpackage

// File: rtl/rx_hp_slot_regs.sv
// rx_hp_slot_regs: ping-pong huge-page base registers, ready flags and sticky error detect.
module rx_hp_slot_regs
    import rx_huge_page_sched_pkg::*;
(
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_wr_en,
    input  logic                  i_wr_slot,
    input  logic [HP_HOST_AW-1:0] i_wr_addr,
    input  logic                  i_cur,
    input  logic                  i_active,
    input  logic                  i_clr,
    input  logic                  i_ovf,
    input  logic                  i_sel,
    output logic [HP_HOST_AW-1:0] o_sel_base,
    output logic [1:0]            o_ready,
    output logic                  o_wr_err
);

    logic [HP_HOST_AW-1:0] r_base [2];
    logic [1:0]            r_ready;
    logic                  r_err;
    logic                  w_block;
    logic                  w_accept;

    assign w_block    = i_wr_en & i_active & (i_wr_slot == i_cur);
    assign w_accept   = i_wr_en & ~w_block;
    assign o_sel_base = r_base[i_sel];
    assign o_ready    = r_ready;
    assign o_wr_err   = r_err;

    // A host write landing on the slot being retired wins over the clear.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_base[0] <= '0;
            r_base[1] <= '0;
            r_ready   <= '0;
            r_err     <= 1'b0;
        end else begin
            if (i_clr)
                r_ready[i_cur] <= 1'b0;
            if (w_accept) begin
                r_ready[i_wr_slot] <= 1'b1;
                r_base[i_wr_slot]  <= i_wr_addr & HP_ALIGN_MASK;
            end
            if (w_block | i_ovf)
                r_err <= 1'b1;
        end
    end

endmodule

// File: rtl/rx_huge_page_sched.sv
// rx_huge_page_sched: ping-pong 2 MB RX huge-page scheduler producing per-TLP host addresses.
module rx_huge_page_sched
    import rx_huge_page_sched_pkg::*;
#(
    parameter int HDR_QWORDS   = HP_HDR_QWORDS,
    parameter int PAGE_QW_LOG2 = HP_PAGE_QW_LOG2
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_hp_wr_en,
    input  logic                  i_hp_wr_slot,
    input  logic [HP_HOST_AW-1:0] i_hp_wr_addr,
    input  logic                  i_tlp_sent,
    input  logic [4:0]            i_tlp_qwords,
    input  logic                  i_change_huge_page,
    output logic                  o_change_huge_page_ack,
    output logic                  o_hp_valid,
    output logic [HP_HOST_AW-1:0] o_tlp_host_addr,
    output logic                  o_closed_req,
    output logic                  o_closed_slot,
    output logic [PAGE_QW_LOG2:0] o_closed_qwords,
    input  logic                  i_closed_ack,
    output logic [1:0]            o_slot_ready,
    output logic                  o_wr_err
);

    localparam int OW = PAGE_QW_LOG2 + 1;
    localparam logic [OW-1:0] HDR = OW'(HDR_QWORDS);

    hp_state_e             r_state;
    hp_state_e             w_state_nxt;
    logic                  r_cur;
    logic [OW-1:0]         r_off;
    logic                  r_ack;
    logic                  r_closed_req;
    logic                  r_closed_slot;
    logic [OW-1:0]         r_closed_qwords;
    logic [HP_HOST_AW-1:0] r_addr;
    logic                  w_valid;
    logic                  w_valid_nxt;
    logic                  w_switch;
    logic                  w_count;
    logic                  w_ovf;
    logic                  w_oth;
    logic                  w_cur_nxt;
    logic [OW-1:0]         w_off_sum;
    logic [OW-1:0]         w_off_nxt;
    logic [HP_HOST_AW-1:0] w_base_nxt;
    logic [1:0]            w_ready;

    assign w_valid     = (r_state == S_ACTIVE) || (r_state == S_NOTIFY);
    assign w_valid_nxt = (w_state_nxt == S_ACTIVE) || (w_state_nxt == S_NOTIFY);
    assign w_switch    = r_state == S_SWITCH;
    assign w_oth       = ~r_cur;
    assign w_count     = w_valid & i_tlp_sent;
    assign w_off_sum   = r_off + OW'(i_tlp_qwords);
    assign w_ovf       = w_count & w_off_sum[PAGE_QW_LOG2];
    assign w_cur_nxt   = r_cur ^ w_switch;
    assign w_off_nxt   = w_switch ? HDR : w_count ? w_off_sum : r_off;

    rx_hp_slot_regs u_slots (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_wr_en    (i_hp_wr_en),
        .i_wr_slot  (i_hp_wr_slot),
        .i_wr_addr  (i_hp_wr_addr),
        .i_cur      (r_cur),
        .i_active   (w_valid),
        .i_clr      (w_switch),
        .i_ovf      (w_ovf),
        .i_sel      (w_cur_nxt),
        .o_sel_base (w_base_nxt),
        .o_ready    (w_ready),
        .o_wr_err   (o_wr_err)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   w_state_nxt = w_ready[r_cur] ? S_ACTIVE : S_IDLE;
            S_ACTIVE: w_state_nxt = !i_change_huge_page ? S_ACTIVE : w_ready[w_oth] ? S_SWITCH : S_WAIT;
            S_WAIT:   w_state_nxt = w_ready[w_oth] ? S_SWITCH : S_WAIT;
            S_SWITCH: w_state_nxt = S_NOTIFY;
            S_NOTIFY: w_state_nxt = i_closed_ack ? S_ACTIVE : S_NOTIFY;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    // Address is built from next-cycle page/offset so it is ready together with hp_valid and ack.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state         <= S_IDLE;
            r_cur           <= 1'b0;
            r_off           <= HDR;
            r_ack           <= 1'b0;
            r_closed_req    <= 1'b0;
            r_closed_slot   <= 1'b0;
            r_closed_qwords <= '0;
            r_addr          <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_cur        <= w_cur_nxt;
            r_off        <= w_off_nxt;
            r_ack        <= w_switch;
            r_closed_req <= w_switch | (r_closed_req & ~i_closed_ack);
            if (w_switch) begin
                r_closed_slot   <= r_cur;
                r_closed_qwords <= r_off;
            end
            if (w_valid_nxt)
                r_addr <= w_base_nxt + HP_HOST_AW'({w_off_nxt, 3'b000});
        end
    end

    assign o_change_huge_page_ack = r_ack;
    assign o_hp_valid             = w_valid;
    assign o_tlp_host_addr        = r_addr;
    assign o_closed_req           = r_closed_req;
    assign o_closed_slot          = r_closed_slot;
    assign o_closed_qwords        = r_closed_qwords;
    assign o_slot_ready           = w_ready;

endmodule

// File: tb/tb_rx_huge_page_sched.sv
// tb_rx_huge_page_sched: scoreboard bench for the RX huge-page scheduler.
module tb_rx_huge_page_sched;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        hp_wr_en = 1'b0;
    logic        hp_wr_slot = 1'b0;
    logic [63:0] hp_wr_addr = '0;
    logic        tlp_sent = 1'b0;
    logic [4:0]  tlp_qwords = '0;
    logic        change = 1'b0;
    logic        ack;
    logic        hp_valid;
    logic [63:0] host_addr;
    logic        closed_req;
    logic        closed_slot;
    logic [18:0] closed_qwords;
    logic        closed_ack = 1'b0;
    logic [1:0]  slot_ready;
    logic        wr_err;

    typedef struct {
        logic        slot;
        logic [18:0] qw;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_errors = 0;
    int          lat;
    logic        mon_prev = 1'b0;
    logic        m_cur = 1'b0;
    logic [18:0] m_off = 19'h10;
    logic [63:0] m_base [2];

    always #5 clk = ~clk;

    rx_huge_page_sched dut (
        .i_clk                  (clk),
        .i_reset                (reset),
        .i_hp_wr_en             (hp_wr_en),
        .i_hp_wr_slot           (hp_wr_slot),
        .i_hp_wr_addr           (hp_wr_addr),
        .i_tlp_sent             (tlp_sent),
        .i_tlp_qwords           (tlp_qwords),
        .i_change_huge_page     (change),
        .o_change_huge_page_ack (ack),
        .o_hp_valid             (hp_valid),
        .o_tlp_host_addr        (host_addr),
        .o_closed_req           (closed_req),
        .o_closed_slot          (closed_slot),
        .o_closed_qwords        (closed_qwords),
        .i_closed_ack           (closed_ack),
        .o_slot_ready           (slot_ready),
        .o_wr_err               (wr_err)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic host_write(input logic slot, input logic [63:0] addr);
        hp_wr_en   = 1'b1;
        hp_wr_slot = slot;
        hp_wr_addr = addr;
        tick();
        hp_wr_en   = 1'b0;
    endtask

    task automatic send(input logic [4:0] q);
        tlp_sent   = 1'b1;
        tlp_qwords = q;
        tick();
        tlp_sent   = 1'b0;
        m_off      = m_off + 19'(q);
    endtask

    task automatic wait_ack(input int max_t, output int n);
        n = 0;
        while (!ack && n < max_t) begin
            tick();
            n++;
        end
        check("ack_seen", {63'd0, ack}, 64'd1);
        change = 1'b0;
        m_cur  = ~m_cur;
        m_off  = 19'h10;
    endtask

    task automatic push_close();
        sb.push_back('{slot: m_cur, qw: m_off});
    endtask

    // Each new notification is matched against the oldest expected page close.
    always @(negedge clk) begin
        if (!reset && closed_req && !mon_prev) begin
            if (sb.size() == 0) begin
                check("sb_underflow", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("closed_slot", {63'd0, closed_slot}, {63'd0, e.slot});
                check("closed_qwords", {45'd0, closed_qwords}, {45'd0, e.qw});
                check("ack_with_req", {63'd0, ack}, 64'd1);
            end
        end
        mon_prev = closed_req && !reset;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        tick();
        tick();
        check("rst_valid", {63'd0, hp_valid}, 64'd0);
        check("rst_addr", host_addr, 64'd0);
        check("rst_req", {63'd0, closed_req}, 64'd0);
        check("rst_ready", {62'd0, slot_ready}, 64'd0);
        check("rst_err", {63'd0, wr_err}, 64'd0);
        check("rst_ack", {63'd0, ack}, 64'd0);
        reset = 1'b0;

        m_base[0] = 64'h1_0020_0000;
        host_write(1'b0, 64'h1_0020_1234);
        check("load_valid_early", {63'd0, hp_valid}, 64'd0);
        check("load_ready", {62'd0, slot_ready}, 64'd1);
        tick();
        check("load_valid", {63'd0, hp_valid}, 64'd1);
        check("load_addr", host_addr, 64'h1_0020_0080);

        closed_ack = 1'b1;
        tick();
        closed_ack = 1'b0;
        check("stray_ack_req", {63'd0, closed_req}, 64'd0);
        check("stray_ack_valid", {63'd0, hp_valid}, 64'd1);

        for (int i = 0; i < 3; i++) send(5'd16);
        check("tlp_addr", host_addr, m_base[m_cur] + {42'd0, m_off, 3'b000});
        check("tlp_addr_abs", host_addr, 64'h1_0020_0200);

        m_base[1] = 64'h2_0000_0000;
        host_write(1'b1, 64'h2_0000_0000);
        change = 1'b1;
        push_close();
        wait_ack(6, lat);
        check("ack_latency", 64'(lat), 64'd2);
        check("switch_addr", host_addr, 64'h2_0000_0080);
        check("switch_ready", {62'd0, slot_ready}, 64'h2);
        check("switch_valid", {63'd0, hp_valid}, 64'd1);
        tick();
        check("ack_pulse", {63'd0, ack}, 64'd0);
        check("req_held", {63'd0, closed_req}, 64'd1);
        send(5'd16);
        check("notify_tlp_addr", host_addr, 64'h2_0000_0100);
        closed_ack = 1'b1;
        tick();
        closed_ack = 1'b0;
        check("req_cleared", {63'd0, closed_req}, 64'd0);

        change = 1'b1;
        push_close();
        tick();
        check("wait_valid", {63'd0, hp_valid}, 64'd0);
        check("wait_ack", {63'd0, ack}, 64'd0);
        tick();
        check("wait_still", {63'd0, ack}, 64'd0);
        m_base[0] = 64'h3_0040_0000;
        host_write(1'b0, 64'h3_0040_0000);
        wait_ack(6, lat);
        check("wait_latency", 64'(lat), 64'd2);
        check("wait_addr", host_addr, 64'h3_0040_0080);
        closed_ack = 1'b1;
        tick();
        closed_ack = 1'b0;

        m_base[1] = 64'h4_0000_0000;
        host_write(1'b1, 64'h4_0000_0000);
        for (int i = 0; i < 3; i++) send(5'd16);
        check("pre_simul_addr", host_addr, 64'h3_0040_0200);
        change     = 1'b1;
        tlp_sent   = 1'b1;
        tlp_qwords = 5'd5;
        m_off      = m_off + 19'd5;
        push_close();
        tick();
        tlp_sent = 1'b0;
        wait_ack(6, lat);
        check("simul_latency", 64'(lat), 64'd1);
        check("simul_addr", host_addr, 64'h4_0000_0080);

        host_write(1'b1, 64'h5_0000_0000);
        check("wr_err_set", {63'd0, wr_err}, 64'd1);
        send(5'd1);
        check("blocked_base", host_addr, 64'h4_0000_0088);
        check("blocked_ready", {62'd0, slot_ready}, 64'h2);
        tick();
        tick();
        check("wr_err_sticky", {63'd0, wr_err}, 64'd1);
        check("notify_pending", {63'd0, closed_req}, 64'd1);

        reset = 1'b1;
        tick();
        check("mid_rst_valid", {63'd0, hp_valid}, 64'd0);
        check("mid_rst_addr", host_addr, 64'd0);
        check("mid_rst_req", {63'd0, closed_req}, 64'd0);
        check("mid_rst_slot", {63'd0, closed_slot}, 64'd0);
        check("mid_rst_qw", {45'd0, closed_qwords}, 64'd0);
        check("mid_rst_ready", {62'd0, slot_ready}, 64'd0);
        check("mid_rst_err", {63'd0, wr_err}, 64'd0);
        check("mid_rst_ack", {63'd0, ack}, 64'd0);
        reset = 1'b0;
        tick();
        check("sb_empty", 64'(sb.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
